// File: rtl/mp_sequencer.sv
// mp_sequencer: single-issue fetch/issue sequencer.
// Walks FETCH -> WAIT -> ISSUE per instruction, redirects on taken branches
// and stops on EBREAK, an external halt request, a retire limit or a
// misaligned branch target.
// Optional build macro SEQ_WATCHDOG_EN: adds a fetch-response watchdog that
// halts with err=1 after 16 silent WAIT cycles.
module mp_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] MAX_INSTR = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        halt_req,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        busy,
    output logic        halted,
    output logic        err,
    output logic [31:0] retire_cnt
);

    localparam logic [31:0] EBREAK = 32'h0010_0073;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_ISSUE,
        S_HALT
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc;
    logic [31:0] instr_q;
    logic [31:0] retire_q;
    logic [31:0] retire_inc;
    logic        err_q;
    logic        halt_pend;
    logic        pend_now;
    logic        wd_expire;
    logic        do_start;
    logic        do_capture;
    logic        do_issue;
    logic        set_err;

`ifdef SEQ_WATCHDOG_EN
    logic [4:0] wd_cnt;

    // Count consecutive silent WAIT cycles; held at zero outside WAIT so it starts fresh on entry.
    always_ff @(posedge clk) begin
        if (rst || state != S_WAIT) begin
            wd_cnt <= '0;
        end else if (!imem_rsp_valid) begin
            wd_cnt <= wd_cnt + 5'd1;
        end
    end

    // Sixteenth consecutive WAIT cycle without a response.
    assign wd_expire = (state == S_WAIT) && !imem_rsp_valid && (wd_cnt == 5'd15);
`else
    assign wd_expire = 1'b0;
`endif

    assign retire_inc = retire_q + 32'd1;
    // A request arriving this cycle counts as pending, so a WAIT response in
    // the same cycle as halt_req is already discarded.
    assign pend_now   = halt_pend | halt_req;

    // Next-state decode plus one-cycle strobes that steer the datapath registers.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
        state_next = state;
        do_start   = 1'b0;
        do_capture = 1'b0;
        do_issue   = 1'b0;
        set_err    = 1'b0;
        case (state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_next = S_FETCH;
                    do_start   = 1'b1;
                end
            end
            S_FETCH: begin
                if (halt_pend) begin
                    state_next = S_HALT;
                end else if (imem_req_ready) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    if (pend_now) begin
                        state_next = S_HALT;
                    end else begin
                        state_next = S_ISSUE;
                        do_capture = 1'b1;
                    end
                end else if (wd_expire) begin
                    state_next = S_HALT;
                    set_err    = 1'b1;
                end
            end
            S_ISSUE: begin
                if (instr_ready) begin
                    do_issue = 1'b1;
                    if (branch_taken && (branch_target[1:0] != 2'b00)) begin
                        state_next = S_HALT;
                        set_err    = 1'b1;
                    end else if ((instr_q == EBREAK) || pend_now ||
                                 ((MAX_INSTR != 32'd0) && (retire_inc == MAX_INSTR))) begin
                        state_next = S_HALT;
                    end else begin
                        state_next = S_FETCH;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State, pc, captured instruction, retire count, error and halt-pending registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state     <= S_IDLE;
            pc        <= RESET_PC;
            retire_q  <= 32'd0;
            instr_q   <= 32'd0;
            err_q     <= 1'b0;
            halt_pend <= 1'b0;
        end else begin
            state <= state_next;
            if (do_start) begin
                pc       <= RESET_PC;
                retire_q <= 32'd0;
                err_q    <= 1'b0;
            end
            if (do_capture) begin
                instr_q <= imem_rsp_data;
            end
            if (do_issue) begin
                retire_q <= retire_inc;
                pc       <= branch_taken ? branch_target : pc + 32'd4;
            end
            if (set_err) begin
                err_q <= 1'b1;
            end
            if (state_next == S_HALT) begin
                halt_pend <= 1'b0;
            end else if (busy && halt_req) begin
                halt_pend <= 1'b1;
            end
        end
    end

    // A pending halt withdraws the fetch request so FETCH can leave without a handshake.
    assign imem_req_valid = (state == S_FETCH) && !halt_pend;
    assign imem_addr      = pc;
    assign instr_valid    = (state == S_ISSUE);
    assign instr_o        = instr_q;
    assign pc_o           = pc;
    assign busy           = (state == S_FETCH) || (state == S_WAIT) || (state == S_ISSUE);
    assign halted         = (state == S_HALT);
    assign err            = err_q;
    assign retire_cnt     = retire_q;

endmodule

// File: tb/tb_mp_sequencer.sv
// tb_mp_sequencer: directed scoreboard bench for mp_sequencer.
// Stimulus pushes expected fetch addresses and issued (pc, instr) pairs;
// a negedge monitor pops and compares whenever the DUT handshakes.
module tb_mp_sequencer;

    localparam logic [31:0] NONE = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        halt_req;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        busy;
    logic        halted;
    logic        err;
    logic [31:0] retire_cnt;

    always #5 clk = ~clk;

    mp_sequencer #(
        .RESET_PC (32'h0000_0000),
        .MAX_INSTR(32'd5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .halt_req      (halt_req),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_addr     (imem_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .busy          (busy),
        .halted        (halted),
        .err           (err),
        .retire_cnt    (retire_cnt)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } issue_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] fetch_q[$];
    issue_t      issue_q[$];

    // Environment configuration, written by the stimulus process only.
    logic [31:0] ebreak_addr = NONE;
    logic [31:0] br_pc       = NONE;
    logic [31:0] br_tgt      = 32'h0;
    logic [31:0] br_pc2      = NONE;
    logic [31:0] br_tgt2     = 32'h0;
    logic [31:0] stall_pc    = NONE;
    int          stall_left  = 0;
    bit          mem_stall   = 1'b0;
    bit          late_rsp    = 1'b0;
    int          stall_seen  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory image: addi x0,x0,addr at every word, EBREAK at ebreak_addr.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == ebreak_addr) return 32'h0010_0073;
        return 32'h0000_0013 | {a[11:0], 20'h0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] instr);
        fetch_q.push_back(pc);
        issue_q.push_back(issue_t'({pc, instr}));
    endtask

    task automatic wait_halt(input string name, input int budget);
        int n = 0;
        @(negedge clk);
        while (!halted && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'b0, halted}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, {31'b0, imem_req_valid}, 32'd0);
        check({tag, "_instr_valid"}, {31'b0, instr_valid}, 32'd0);
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_halted"}, {31'b0, halted}, 32'd0);
        check({tag, "_err"}, {31'b0, err}, 32'd0);
        check({tag, "_retire"}, retire_cnt, 32'd0);
        check({tag, "_instr_o"}, instr_o, 32'd0);
        check({tag, "_pc_o"}, pc_o, 32'd0);
    endtask

    // Memory, branch and decode-ready model; drives 2 time units after each rising edge.
    initial begin
        bit          hs;
        logic [31:0] hs_addr;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'hDEAD_BEEF;
        instr_ready    = 1'b1;
        branch_taken   = 1'b0;
        branch_target  = 32'h0BAD_0001;
        forever begin
            @(negedge clk);
            hs      = imem_req_valid && imem_req_ready;
            hs_addr = imem_addr;
            @(posedge clk);
            #2;
            imem_rsp_valid = (hs && !mem_stall) || late_rsp;
            if (late_rsp)            imem_rsp_data = 32'h1234_5678;
            else if (imem_rsp_valid) imem_rsp_data = mem_word(hs_addr);
            else                     imem_rsp_data = 32'hDEAD_BEEF;
            branch_taken  = 1'b0;
            branch_target = 32'h0BAD_0001;
            if (instr_valid && pc_o == br_pc) begin
                branch_taken  = 1'b1;
                branch_target = br_tgt;
            end else if (instr_valid && pc_o == br_pc2) begin
                branch_taken  = 1'b1;
                branch_target = br_tgt2;
            end
            if (instr_valid && pc_o == stall_pc && stall_left > 0) begin
                instr_ready = 1'b0;
                stall_left--;
            end else begin
                instr_ready = 1'b1;
            end
        end
    end

    // Scoreboard monitor: compares fetch addresses and issued instructions against the queues.
    always @(negedge clk) begin
        if (imem_req_valid && imem_req_ready) begin
            if (fetch_q.size() == 0) check("fetch_q_size", fetch_q.size(), 1);
            else                     check("fetch_addr", imem_addr, fetch_q.pop_front());
        end
        if (instr_valid) begin
            if (issue_q.size() == 0) begin
                check("issue_q_size", issue_q.size(), 1);
            end else begin
                check(instr_ready ? "issue_pc" : "hold_pc", pc_o, issue_q[0].pc);
                check(instr_ready ? "issue_instr" : "hold_instr", instr_o, issue_q[0].instr);
                if (instr_ready) void'(issue_q.pop_front());
                else             stall_seen++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit found;
        rst      = 1'b1;
        start    = 1'b0;
        halt_req = 1'b0;

        // Reset: outputs held at reset values during and after rst.
        repeat (3) tick();
        @(negedge clk);
        check_reset_outputs("rst_during");
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_after");

        // Straight-line program; MAX_INSTR=5 stops it after the fifth retire.
        push(32'h00, 32'h0000_0013);
        push(32'h04, 32'h0040_0013);
        push(32'h08, 32'h0080_0013);
        push(32'h0C, 32'h00C0_0013);
        push(32'h10, 32'h0100_0013);
        pulse_start();
        repeat (9) tick();
        @(negedge clk);
        check("t1_retire_after_9", retire_cnt, 32'd3);
        wait_halt("t1_halt", 40);
        check("t1_retire_max", retire_cnt, 32'd5);
        check("t1_err", {31'b0, err}, 32'd0);
        check("t1_busy", {31'b0, busy}, 32'd0);

        // Branch at pc=8 to 0x40, then misaligned branch at 0x40 to 0x42.
        br_pc   = 32'h08;  br_tgt  = 32'h40;
        br_pc2  = 32'h40;  br_tgt2 = 32'h42;
        push(32'h00, 32'h0000_0013);
        push(32'h04, 32'h0040_0013);
        push(32'h08, 32'h0080_0013);
        push(32'h40, 32'h0400_0013);
        pulse_start();
        wait_halt("t2_halt", 40);
        check("t2_err", {31'b0, err}, 32'd1);
        check("t2_retire", retire_cnt, 32'd4);
        check("t2_fault_pc", pc_o, 32'h42);

        // EBREAK at 0xC; the restart also clears err.
        br_pc       = NONE;
        br_pc2      = NONE;
        ebreak_addr = 32'h0C;
        push(32'h00, 32'h0000_0013);
        push(32'h04, 32'h0040_0013);
        push(32'h08, 32'h0080_0013);
        push(32'h0C, 32'h0010_0073);
        pulse_start();
        @(negedge clk);
        check("t3_err_cleared", {31'b0, err}, 32'd0);
        wait_halt("t3_halt", 40);
        check("t3_retire", retire_cnt, 32'd4);

        // Restart from HALT, then halt_req during the WAIT for pc=8.
        ebreak_addr = NONE;
        fetch_q.push_back(32'h00);
        issue_q.push_back(issue_t'({32'h00, 32'h0000_0013}));
        fetch_q.push_back(32'h04);
        issue_q.push_back(issue_t'({32'h04, 32'h0040_0013}));
        fetch_q.push_back(32'h08);
        pulse_start();
        @(negedge clk);
        check("t3b_addr_restart", imem_addr, 32'h0);
        check("t3b_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("t3b_retire_clear", retire_cnt, 32'd0);
        tick();
        repeat (6) tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        @(negedge clk);
        check("t3b_halted", {31'b0, halted}, 32'd1);
        check("t3b_retire_kept", retire_cnt, 32'd2);
        check("t3b_rsp_discarded", instr_o, 32'h0040_0013);

        // instr_ready low for 7 cycles at pc=4, then rst during the WAIT for pc=8.
        stall_pc   = 32'h04;
        stall_left = 7;
        push(32'h00, 32'h0000_0013);
        push(32'h04, 32'h0040_0013);
        fetch_q.push_back(32'h08);
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready && imem_addr == 32'h08) found = 1'b1;
        end
        check("t4_fetch8_seen", {31'b0, found}, 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        late_rsp = 1'b1;
        @(negedge clk);
        check_reset_outputs("t4_rst_wait");
        tick();
        late_rsp = 1'b0;
        @(negedge clk);
        check("t4_late_instr", instr_o, 32'd0);
        check("t4_late_busy", {31'b0, busy}, 32'd0);
        check("t4_stall_cycles", stall_seen, 32'd7);
        stall_pc = NONE;

        // Response withheld: watchdog halt when enabled, indefinite WAIT otherwise.
        mem_stall = 1'b1;
        fetch_q.push_back(32'h00);
        pulse_start();
`ifdef SEQ_WATCHDOG_EN
        repeat (20) tick();
        @(negedge clk);
        check("t5_wd_halted", {31'b0, halted}, 32'd1);
        check("t5_wd_err", {31'b0, err}, 32'd1);
`else
        repeat (100) tick();
        @(negedge clk);
        check("t5_no_halt", {31'b0, halted}, 32'd0);
        check("t5_still_busy", {31'b0, busy}, 32'd1);
        check("t5_no_err", {31'b0, err}, 32'd0);
`endif
        tick();
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        mem_stall = 1'b0;
        @(negedge clk);
        check_reset_outputs("t5_rst");

        check("end_fetch_q_empty", fetch_q.size(), 32'd0);
        check("end_issue_q_empty", issue_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mp_sequencer.md
MP_SEQUENCER -- requirements
Module: mp_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, start address loaded on every start.
REQ-002 Parameter MAX_INSTR, default 0, retire limit before automatic halt; 0 means unlimited.
REQ-003 Port clk  input  1  single clock; all state on rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port start  input  1  one-cycle pulse; begins execution from IDLE or HALT.
REQ-006 Port halt_req  input  1  external stop request.
REQ-007 Port imem_req_valid / imem_req_ready  output / input  1 each  fetch request handshake.
REQ-008 Port imem_addr  output  32  fetch address, equals pc.
REQ-009 Port imem_rsp_valid / imem_rsp_data  input  1 / 32  fetch response.
REQ-010 Port instr_valid / instr_ready  output / input  1 each  issue handshake toward decode/execute.
REQ-011 Port instr_o / pc_o  output  32 each  issued instruction and its address.
REQ-012 Port branch_taken / branch_target  input  1 / 32  redirect, sampled only on the issue handshake.
REQ-013 Port busy / halted / err  output  1 each  status flags.
REQ-014 Port retire_cnt  output  32  count of accepted instructions.

Function
REQ-015 FSM states: IDLE, FETCH, WAIT, ISSUE, HALT; exactly one state active.
REQ-016 IDLE: start -> FETCH, pc=RESET_PC, retire_cnt=0, err=0; all other inputs ignored.
REQ-017 FETCH: imem_req_valid=1 and imem_addr=pc; on imem_req_ready -> WAIT in the next cycle.
REQ-018 WAIT: on imem_rsp_valid, capture imem_rsp_data into instr_o -> ISSUE in the next cycle; imem_rsp_valid in any other state is ignored.
REQ-019 ISSUE: instr_valid=1; instr_o and pc_o are held stable until instr_ready.
REQ-020 Issue handshake (instr_valid && instr_ready):
- retire_cnt increments, wrapping modulo 2^32.
- pc = branch_target if branch_taken, else pc+4 (modulo 2^32).
REQ-021 After the issue handshake, the next state is HALT if any of the following hold, else FETCH:
- instr_o == 32'h0010_0073 (EBREAK);
- halt pending;
- MAX_INSTR != 0 and the new retire_cnt == MAX_INSTR.
REQ-022 branch_taken with branch_target[1:0] != 0 -> HALT with err=1; pc keeps the faulting target value.
REQ-023 halt_req in any non-IDLE/non-HALT state sets a halt-pending flag, cleared on entry to HALT.
- FETCH with pending, before the request is accepted -> HALT.
- WAIT with pending: the response is consumed and discarded -> HALT, no issue.
- ISSUE with pending: HALT follows the issue handshake.
REQ-024 halt_req and start in the same cycle while in IDLE or HALT: start wins.
REQ-025 HALT: halted=1; start -> FETCH with pc=RESET_PC, retire_cnt=0, err=0.
REQ-026 busy=1 in FETCH, WAIT and ISSUE; otherwise 0.
REQ-027 Best-case throughput: one instruction per 3 cycles (FETCH, WAIT with immediate response, ISSUE with ready).

Reset
REQ-028 rst=1 forces, in the same edge: state=IDLE, pc=RESET_PC, retire_cnt=0, instr_o=0, err=0, halt-pending=0.
REQ-029 Outputs during and after reset: imem_req_valid=0, instr_valid=0, busy=0, halted=0.
REQ-030 Reset asserted mid-fetch abandons the outstanding request; a late response is ignored in IDLE.

Configuration
REQ-031 Macro SEQ_WATCHDOG_EN, when defined, adds a 5-bit wait counter cleared on entry to WAIT.
- If 16 cycles pass in WAIT without imem_rsp_valid -> HALT with err=1.
REQ-032 Without SEQ_WATCHDOG_EN, WAIT lasts indefinitely and err is driven only by REQ-022.

Verification
REQ-033 Reset, then start; memory always ready and responding next cycle with addi words -> imem_addr 0,4,8,...; retire_cnt=3 after 9 cycles.
REQ-034 Issue at pc=8 with branch_taken=1, branch_target=0x40 -> next imem_addr=0x40; branch_target=0x42 -> halted=1, err=1.
REQ-035 Fetch returns 32'h0010_0073 at pc=0xC -> HALT after its handshake, retire_cnt=4; start -> imem_addr=0 again, retire_cnt=0.
REQ-036 MAX_INSTR=5, unlimited program -> halted=1 with retire_cnt=5; halt_req pulsed in WAIT -> response discarded, retire_cnt unchanged.
REQ-037 instr_ready held low for 7 cycles -> instr_o/pc_o stable throughout; rst pulsed in WAIT -> IDLE next cycle, all outputs at reset values.
REQ-038 With SEQ_WATCHDOG_EN defined, rsp withheld 16 cycles -> halted=1, err=1; without it, no halt after 100 cycles.
